sm_to_twos_serial: RTL and testbench
====================================

# sm_to_twos_serial

Digit-serial converter from sign-magnitude to two's complement. It is the inverse of the combinational absolute-value datapath: given `sign` and `|x|`, it rebuilds `x`. A carry-propagating conditional negation runs over `DIGIT` bits per clock, and a valid/ready handshake sits on each side. It goes in the FHE-optimisation benchmark flow as the sequential restore stage after magnitude-domain arithmetic.

## Interface
Parameters:
- `WIDTH`, default 32: word width; must be ≥ 2.
- `DIGIT`, default 8: bits processed per cycle; must divide `WIDTH`.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: input word present.
- `in_ready`, output, 1: high only in IDLE and only while `rst` is low.
- `in_sign`, input, 1: 1 means negative.
- `in_mag`, input, `WIDTH`: unsigned magnitude.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts the result.
- `out_data`, output, `WIDTH`: two's-complement result.
- `out_ovf`, output, 1: result is not representable.

## Operation
- Derived constant: `N = WIDTH/DIGIT`.
- FSM states are IDLE, BUSY and DONE.
- **IDLE.**
  - `in_ready` = 1.
  - A handshake (`in_valid && in_ready`) latches `in_sign` and `in_mag` into a shift register, sets `carry` = `in_sign`, clears the digit counter and goes to BUSY.
  - `out_ovf` is computed at accept and held until the next accept:
    - `(!in_sign && in_mag[WIDTH-1])`, or
    - `(in_sign && in_mag[WIDTH-1] && in_mag[WIDTH-2:0] != 0)`.
- **BUSY.** Each cycle processes the lowest digit `d`:
  - If sign = 1: `r = ~d + carry`, and `carry` takes the digit carry-out.
  - If sign = 0: `r = d`.
  - `r` is shifted in from the top, so after N cycles the word sits LSB-aligned.
  - The counter increments each cycle; after the Nth digit the state goes to DONE.
- **DONE.**
  - `out_valid` = 1.
  - `out_data` and `out_ovf` are stable and equal the registered result.
  - `out_valid && out_ready` returns the FSM to IDLE.
- Arithmetic is modulo 2^WIDTH:
  - `sign=1, mag=0` (negative zero) gives 0 with `out_ovf` = 0.
  - `sign=1, mag=2^(WIDTH-1)` gives `0x80..0` with `out_ovf` = 0.
- On overflow, `out_data` is still the modulo result: `mag` or `-mag`.
- `in_valid` outside IDLE is ignored, and input values are sampled only at the handshake.
- **Reset**, at any state including mid-BUSY, on the next edge:
  - State goes to IDLE and the counter clears.
  - `out_valid`, `out_ovf` and `out_data` go to 0.
  - No partial result is ever presented.

## Timing
- Handshake in cycle 0. BUSY occupies cycles 1..N, and `out_valid` rises in cycle N+1 (cycle 5 for the defaults).
- The output handshake in cycle k puts the FSM in IDLE in cycle k+1, so `in_ready` = 1 in k+1.
- Minimum initiation interval is N+2 cycles, with no overlap between words.
- `in_ready` is combinational from state and `rst` only; it never depends on `in_valid`.
- `out_valid` is a registered state decode. `out_ready` is sampled only in DONE, and holding it high early has no effect.
- Backpressure: DONE holds indefinitely and outputs do not change.
- Reset values are `in_ready` = 0 while `rst` is high (1 once `rst` is low and the FSM is in IDLE), and 0 for `out_valid`, `out_data` and `out_ovf`.

## Structure
- Package `sm_twos_pkg` holds:
  - the state enum `sm_state_t`: IDLE, BUSY, DONE;
  - a function computing `N` and the counter width `$clog2(N)` (minimum 1);
  - an elaboration-time check that `WIDTH % DIGIT == 0`.
- Sub-module `cond_negate_digit` is combinational, `DIGIT` wide, with ports:
  - inputs `d`, `neg`, `cin`;
  - outputs `r`, `cout`.
  - It computes `r,cout = neg ? ~d + cin : {d, 1'b0}`.
- The top level holds the FSM, counter, shift register, carry register and overflow register.

## Test plan
All scenarios use defaults 32/8 unless noted.
1. sign=1, mag=0x00000001 → `out_data` = 0xFFFFFFFF, `out_ovf` = 0; `out_valid` first high exactly 5 cycles after the handshake.
2. sign=0, mag=0x12345678 → 0x12345678, ovf 0. Then sign=0, mag=0x80000000 → 0x80000000, ovf 1. Then sign=1, mag=0x80000000 → 0x80000000, ovf 0. Then sign=1, mag=0x80000001 → 0x7FFFFFFF, ovf 1.
3. sign=1, mag=0 → 0x00000000, ovf 0; exercises the carry rippling through all 4 digits. Follow with sign=1, mag=0x00000100 → 0xFFFFFF00, checking the carry crossing a digit boundary.
4. Backpressure:
   - Stimulus: `out_ready` = 0 for 3 DONE cycles while `in_valid` = 1 with different data.
   - Required: `out_data` and `out_ovf` stable; `in_ready` = 0; new data not latched.
   - Stimulus: `out_ready` = 1.
   - Required: IDLE next cycle with `in_ready` = 1.
5. Reset in BUSY cycle 2 → next cycle IDLE with `out_valid` = 0 and `out_data` = 0. A following sign=1, mag=5 → 0xFFFFFFFB.
6. Round trip: for 1000 random 32-bit `x`, feed sign=`x[31]`, mag=`|x|` mod 2^32 → `out_data` == `x`, ovf 0. Repeat with WIDTH=16, DIGIT=4 and DIGIT=16 (N=1, latency 2).

Source files
------------

// File: rtl/sm_to_twos_serial_pkg.sv
// Shared types and elaboration helpers for the sign-magnitude to
// two's-complement digit-serial converter.
package sm_twos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sm_state_t;

  // Number of digits processed per word.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; never narrower than one bit so N == 1 still works.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Legal configuration: word of at least two bits, split into whole digits.
  function automatic bit cfg_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) &&
           ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/sm_to_twos_serial_if.sv
// Input and output valid/ready channels of the converter.
interface sm_to_twos_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [WIDTH-1:0] in_mag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  // Producer/consumer side (drives words in, accepts results).
  modport master (
    output in_valid, in_sign, in_mag, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // Converter side.
  modport slave (
    input  in_valid, in_sign, in_mag, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/sm_to_twos_serial_cond_negate_digit.sv
// One digit of a carry-propagating conditional negation:
// neg=1 gives ~d + cin with carry-out, neg=0 passes d with no carry.
module cond_negate_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] d,
  input  logic             neg,
  input  logic             cin,
  output logic [DIGIT-1:0] r,
  output logic             cout
);

  logic [DIGIT:0] sum;

  // Invert-and-increment digit slice, bypassed when the word is positive.
  always_comb begin
    sum = {1'b0, ~d} + {{DIGIT{1'b0}}, cin};
    if (neg) begin
      r    = sum[DIGIT-1:0];
      cout = sum[DIGIT];
    end else begin
      r    = d;
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/sm_to_twos_serial.sv
// Digit-serial sign-magnitude to two's-complement converter. A word is
// accepted in IDLE, negated DIGIT bits per cycle in BUSY (LSB digit first,
// results shifted in from the top), and held in DONE until consumed.
module sm_to_twos_serial
  import sm_twos_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input logic                clk,
  input logic                rst,
  sm_to_twos_serial_if.slave bus
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);

  if (!cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("sm_to_twos_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  sm_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             carry_q, carry_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             mag_ovf;
  logic [DIGIT-1:0] digit_r;
  logic             digit_cout;
  logic [WIDTH-1:0] shifted;

  // in_ready depends only on state and reset, never on in_valid.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = shreg_q;
  assign bus.out_ovf   = ovf_q;

  // Positive magnitudes need the top bit clear; negative ones may reach -2^(W-1).
  assign mag_ovf = bus.in_sign ? (bus.in_mag[WIDTH-1] && (|bus.in_mag[WIDTH-2:0]))
                               :  bus.in_mag[WIDTH-1];

  cond_negate_digit #(.DIGIT(DIGIT)) u_digit (
    .d    (shreg_q[DIGIT-1:0]),
    .neg  (sign_q),
    .cin  (carry_q),
    .r    (digit_r),
    .cout (digit_cout)
  );

  if (N == 1) begin : g_single
    assign shifted = digit_r;
  end else begin : g_multi
    assign shifted = {digit_r, shreg_q[WIDTH-1:DIGIT]};
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    // NOTE: every target takes its held value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.in_mag;
          sign_d  = bus.in_sign;
          carry_d = bus.in_sign;
          cnt_d   = '0;
          ovf_d   = mag_ovf;
          state_d = BUSY;
        end
      end
      BUSY: begin
        shreg_d = shifted;
        carry_d = digit_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      // NOTE: the shift register is reset too, because it drives out_data directly.
      shreg_q <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sm_to_twos_serial.sv
// Directed and round-trip bench for sm_to_twos_serial. Three instances:
// sel 0 = 32/8 (N=4), sel 1 = 16/4 (N=4), sel 2 = 16/16 (N=1).
module tb_sm_to_twos_serial;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  sm_to_twos_serial_if #(.WIDTH(32)) bus_a ();
  sm_to_twos_serial_if #(.WIDTH(16)) bus_b ();
  sm_to_twos_serial_if #(.WIDTH(16)) bus_c ();

  sm_to_twos_serial #(.WIDTH(32), .DIGIT(8))  u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sm_to_twos_serial #(.WIDTH(16), .DIGIT(4))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  sm_to_twos_serial #(.WIDTH(16), .DIGIT(16)) u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---- access helpers (drive/read one instance) ----
  task automatic set_in(input int sel, input logic v, input logic s, input logic [31:0] m);
    case (sel)
      0:       begin bus_a.in_valid = v; bus_a.in_sign = s; bus_a.in_mag = m;        end
      1:       begin bus_b.in_valid = v; bus_b.in_sign = s; bus_b.in_mag = m[15:0];  end
      default: begin bus_c.in_valid = v; bus_c.in_sign = s; bus_c.in_mag = m[15:0];  end
    endcase
  endtask

  task automatic set_or(input int sel, input logic r);
    case (sel)
      0:       bus_a.out_ready = r;
      1:       bus_b.out_ready = r;
      default: bus_c.out_ready = r;
    endcase
  endtask

  function automatic logic get_ir(input int sel);
    case (sel)
      0:       return bus_a.in_ready;
      1:       return bus_b.in_ready;
      default: return bus_c.in_ready;
    endcase
  endfunction

  function automatic logic get_ov(input int sel);
    case (sel)
      0:       return bus_a.out_valid;
      1:       return bus_b.out_valid;
      default: return bus_c.out_valid;
    endcase
  endfunction

  function automatic logic [31:0] get_data(input int sel);
    case (sel)
      0:       return bus_a.out_data;
      1:       return {16'h0, bus_b.out_data};
      default: return {16'h0, bus_c.out_data};
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0:       return bus_a.out_ovf;
      1:       return bus_b.out_ovf;
      default: return bus_c.out_ovf;
    endcase
  endfunction

  // Handshake one word and wait (bounded) for out_valid; leaves DONE unconsumed.
  // lat counts cycles from the handshake cycle (0) to the first out_valid cycle.
  task automatic start_wait(input int sel, input logic s, input logic [31:0] m,
                            output int lat, output bit ok);
    int t;
    ok = 1'b1;
    @(negedge clk);
    t = 0;
    while (!get_ir(sel) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL start_timeout sel=%0d: in_ready never rose", sel);
      ok = 1'b0;
      return;
    end
    set_in(sel, 1'b1, s, m);
    @(negedge clk);
    set_in(sel, 1'b0, 1'b0, 32'h0);
    lat = 1;
    while (!get_ov(sel) && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout sel=%0d: out_valid never rose", sel);
      ok = 1'b0;
    end
  endtask

  task automatic release_word(input int sel);
    set_or(sel, 1'b1);
    @(negedge clk);
    set_or(sel, 1'b0);
  endtask

  // One full transaction with result, overflow and latency comparisons.
  task automatic expect_word(input string name, input int sel, input logic s,
                             input logic [31:0] m, input logic [31:0] exp_data,
                             input logic exp_ovf, input int exp_lat);
    int lat;
    bit ok;
    start_wait(sel, s, m, lat, ok);
    if (ok) begin
      n_cmp++;
      if (get_data(sel) !== exp_data) begin
        n_bad++;
        $display("FAIL %s data: got %h want %h", name, get_data(sel), exp_data);
      end
      n_cmp++;
      if (get_ovf(sel) !== exp_ovf) begin
        n_bad++;
        $display("FAIL %s ovf: got %b want %b", name, get_ovf(sel), exp_ovf);
      end
      n_cmp++;
      if (lat != exp_lat) begin
        n_bad++;
        $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      release_word(sel);
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus_a.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus_a.in_ready); end
    n_cmp++;
    if (bus_a.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus_a.out_valid); end
    n_cmp++;
    if (bus_a.out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", bus_a.out_data); end
    n_cmp++;
    if (bus_a.out_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_out_ovf: got %b want 0", bus_a.out_ovf); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_a.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b want 1", bus_a.in_ready); end
  endtask

  task automatic test_basic();
    expect_word("neg_one", 0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 5);
    n_cmp++;
    if (bus_a.in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_after_consume: in_ready got %b want 1", bus_a.in_ready); end
  endtask

  task automatic test_boundaries();
    expect_word("pos_plain",   0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0, 5);
    expect_word("pos_ovf",     0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 5);
    expect_word("neg_min",     0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 5);
    expect_word("neg_ovf",     0, 1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 5);
  endtask

  task automatic test_carry();
    expect_word("neg_zero",    0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 5);
    expect_word("carry_cross", 0, 1'b1, 32'h0000_0100, 32'hFFFF_FF00, 1'b0, 5);
  endtask

  task automatic test_early_ready();
    int  lat;
    bit  ok;
    set_or(0, 1'b1);
    start_wait(0, 1'b0, 32'h0000_0ABC, lat, ok);
    if (ok) begin
      n_cmp++;
      if (lat != 5) begin n_bad++; $display("FAIL early_ready latency: got %0d want 5", lat); end
      n_cmp++;
      if (bus_a.out_data !== 32'h0000_0ABC) begin n_bad++; $display("FAIL early_ready data: got %h want 00000abc", bus_a.out_data); end
      @(negedge clk);
      n_cmp++;
      if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL early_ready consume: valid=%b ready=%b want 0/1", bus_a.out_valid, bus_a.in_ready);
      end
    end
    set_or(0, 1'b0);
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  ok;
    bit  seen;
    start_wait(0, 1'b0, 32'h8000_0000, lat, ok);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        set_in(0, 1'b1, 1'b1, 32'h0000_0003 + i);
        @(negedge clk);
        n_cmp++;
        if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_hold%0d: valid=%b ready=%b want 1/0", i, bus_a.out_valid, bus_a.in_ready);
        end
        n_cmp++;
        if (bus_a.out_data !== 32'h8000_0000 || bus_a.out_ovf !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_stable%0d: data=%h ovf=%b want 80000000/1", i, bus_a.out_data, bus_a.out_ovf);
        end
      end
      set_in(0, 1'b0, 1'b0, 32'h0);
      release_word(0);
      n_cmp++;
      if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_release: ready=%b valid=%b want 1/0", bus_a.in_ready, bus_a.out_valid);
      end
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (bus_a.out_valid === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_bad++; $display("FAIL bp_no_latch: out_valid got 1 want 0"); end
      n_cmp++;
      if (bus_a.out_ovf !== 1'b1) begin n_bad++; $display("FAIL bp_ovf_held: got %b want 1", bus_a.out_ovf); end
    end
  endtask

  task automatic test_reset_mid_busy();
    bit seen;
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 32'h8000_0000);
    @(negedge clk);                       // cycle 1 (BUSY)
    set_in(0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);                       // cycle 2 (BUSY)
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_rst outputs: valid=%b data=%h want 0/0", bus_a.out_valid, bus_a.out_data);
    end
    n_cmp++;
    if (bus_a.out_ovf !== 1'b0 || bus_a.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst flags: ovf=%b ready=%b want 0/0", bus_a.out_ovf, bus_a.in_ready);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_rst idle: partial_valid=%b ready=%b want 0/1", seen, bus_a.in_ready);
    end
    expect_word("after_rst", 0, 1'b1, 32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 5);
  endtask

  task automatic test_roundtrip(input int sel, input int w, input int n);
    logic [31:0] mask;
    logic [31:0] x;
    logic [31:0] m;
    logic        s;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < 1000; i++) begin
      case (i)
        0:       x = 32'd1 << (w - 1);
        1:       x = 32'd0;
        2:       x = mask;
        default: x = $urandom & mask;
      endcase
      s = x[w-1];
      m = s ? ((~x + 32'd1) & mask) : x;
      expect_word($sformatf("rt_sel%0d_x%h", sel, x), sel, s, m, x, 1'b0, n + 1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(k, 1'b0, 1'b0, 32'h0);
      set_or(k, 1'b0);
    end
    test_reset();
    test_basic();
    test_boundaries();
    test_carry();
    test_early_ready();
    test_backpressure();
    test_reset_mid_busy();
    test_roundtrip(0, 32, 4);
    test_roundtrip(1, 16, 4);
    test_roundtrip(2, 16, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
